siso: RTL and testbench
=======================

// Module: siso
// PURPOSE
//   Serial-in, serial-out (SISO) shift register. One bit enters per rising clock
//   edge and leaves DEPTH clock edges later, unchanged and in order.
//   Used as a fixed bit delay line / serial pipeline stage between serial links.
//   Fully synchronous datapath with an asynchronous active-low clear.
// PARAMETERS
//   DEPTH      4     number of flip-flop stages (>=1); sets the s_in->s_out latency
//   RESET_VAL  1'b0  value loaded into every stage while clear is asserted
// PORTS
//   clk    input   1  single clock; all state updates on the rising edge
//   clear  input   1  reset; asynchronous, active-low (0 = clear all stages)
//   s_in   input   1  serial data input, sampled on each rising clk edge
//   s_out  output  1  serial data output = last stage; driven directly from a flop
// BEHAVIOUR
//   - Interface: one clock (clk). Reset (clear) is asynchronous and active-low.
//   - State: register stage[0..DEPTH-1]. s_out = stage[DEPTH-1] (no combinational path
//     from s_in to s_out).
//   - Reset: clear=0 immediately (no clock needed) forces every stage, and so s_out,
//     to RESET_VAL. State holds RESET_VAL for as long as clear=0; clock edges are ignored.
//   - Shift: on each rising clk edge with clear=1: stage[0]<=s_in and
//     stage[i]<=stage[i-1] for i=1..DEPTH-1. All stages update together on the same edge.
//   - Latency: the value of s_in sampled at edge k appears on s_out just after edge k+DEPTH-1.
//     That is, DEPTH edges in total counting edge k itself.
//     DEPTH=1 gives s_out equal to s_in from the previous edge.
//   - No enable and no parallel load. A shift happens on every clock edge while
//     clear is deasserted.
//   - Reset release: the first rising edge after clear returns to 1 performs a
//     normal shift. No dead cycle is inserted.
//   - Reset mid-stream: asserting clear discards all bits in flight.
//     After release, s_out shows RESET_VAL until new data has travelled through
//     all DEPTH stages.
//   - Unknown input: X/Z on s_in is stored as-is and propagates to s_out DEPTH
//     edges later. The design must not mask or convert it.
//   - Same-time edges: if clear is asserted at the same moment as a clock edge,
//     the clear wins.
//   - No outputs other than s_out. No handshake.
// TESTING (DEPTH=4, clk period 10 ns, rising edges at 5,15,25,...)
//   1 Power-up clear: clear=0 from t=0 with s_in=0; check s_out=0 straight away
//     and at every edge while clear is low.
//   2 Async clear: preload 1111, then drop clear between two clock edges.
//     Check s_out goes to 0 before the next edge; release clear and check it
//     stays 0 for 4 edges while s_in=0.
//   3 Single pulse: after release, s_in=1 for exactly one edge, then 0.
//     Check s_out=1 for exactly one cycle, starting just after the 4th edge
//     counted from the edge that sampled the 1.
//   4 Pattern: drive s_in 1,0,0,1,0 on consecutive edges, then 0s.
//     Check s_out shows 1,0,0,1,0 delayed by 4 edges, with no bit lost or repeated.
//   5 Streaming: drive 64 random bits. The scoreboard compares s_out against
//     s_in from 4 edges earlier, on every edge.
//   6 X propagation and mid-stream clear: drive s_in=X for one edge and check
//     s_out=X 4 edges later. Assert clear while bits are still in flight;
//     check s_out=0 at once and that no stale bit comes out after release.

Source files
------------

// File: rtl/siso.sv
// Serial-in serial-out shift register: each bit on s_in reappears on s_out
// DEPTH rising edges later. An active-low asynchronous clear loads RESET_VAL into every stage.
module siso #(
  parameter int unsigned DEPTH     = 4,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic clear,
  input  logic s_in,
  output logic s_out
);

  logic stage_reg [DEPTH];
  logic stage_next [DEPTH];

  // Stage 0 takes s_in. Each later stage takes the stage before it.
  // A generate-if keeps the index of stage 0 in range, so DEPTH=1 still builds.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = s_in;
      end else begin : g_body
        assign stage_next[gi] = stage_reg[gi-1];
      end

      always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
          stage_reg[gi] <= RESET_VAL;
        end else begin
          stage_reg[gi] <= stage_next[gi];
        end
      end
    end
  endgenerate

  assign s_out = stage_reg[DEPTH-1];

endmodule

// File: tb/tb_siso.sv
// Self-checking bench for siso (DEPTH=4). A queue holds the history of s_in
// since the last clear. The expected s_out is the entry DEPTH back, or RESET_VAL when history is short.
module tb_siso;

  localparam int unsigned DEPTH = 4;
  localparam logic        RST_V = 1'b0;

  logic clk   = 1'b0;
  logic clear = 1'b0;
  logic s_in  = 1'b0;
  logic s_out;

  int   checks = 0;
  int   errors = 0;
  logic hist  [$];
  logic out_q [$];

  siso #(.DEPTH(DEPTH), .RESET_VAL(RST_V)) dut (
    .clk   (clk),
    .clear (clear),
    .s_in  (s_in),
    .s_out (s_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic expected_out();
    if (hist.size() >= DEPTH) return hist[hist.size() - DEPTH];
    return RST_V;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Call at a falling edge. Drives v and takes one rising edge, then checks
  // against the model and returns at the next falling edge.
  task automatic tick(input string tag, input logic v);
    logic sampled;
    s_in = v;
    @(posedge clk);
    sampled = s_in;
    if (clear) hist.push_back(sampled);
    else       hist.delete();
    #1;
    chk(tag, s_out, expected_out());
    $display("t=%0t %s clear=%b s_in=%b s_out=%b exp=%b", $time, tag, clear, sampled, s_out, expected_out());
    out_q.push_back(s_out);
    @(negedge clk);
  endtask

  // Asserts clear between edges. The output must follow at once, with no clock edge.
  task automatic async_clear(input string tag);
    #2;
    clear = 1'b0;
    hist.delete();
    #1;
    chk(tag, s_out, RST_V);
    $display("t=%0t %s clear asserted s_out=%b", $time, tag, s_out);
  endtask

  task automatic release_clear();
    #1;
    clear = 1'b1;
  endtask

  initial begin
    int ones;
    logic [4:0] pat;
    logic [4:0] got;
    logic       x_sampled;

    // 1: power-up clear
    #1;
    chk("powerup_t0", s_out, RST_V);
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick("powerup_hold", 1'b0);

    // 2: preload 1111, then an async clear between edges
    release_clear();
    @(negedge clk);
    for (int i = 0; i < 4; i++) tick("preload", 1'b1);
    chk("preload_full", s_out, 1'b1);
    async_clear("async_clear");
    release_clear();
    for (int i = 0; i < 4; i++) tick("post_clear_zero", 1'b0);

    // 3: single pulse
    out_q.delete();
    tick("pulse", 1'b1);
    for (int i = 0; i < 8; i++) tick("pulse_tail", 1'b0);
    ones = 0;
    foreach (out_q[i]) if (out_q[i] === 1'b1) ones++;
    chk("pulse_once", (ones == 1), 1'b1);
    chk("pulse_latency", out_q[DEPTH-1], 1'b1);

    // 4: fixed pattern 1,0,0,1,0
    out_q.delete();
    pat = 5'b10010;
    for (int i = 4; i >= 0; i--) tick("pattern", pat[i]);
    for (int i = 0; i < 6; i++) tick("pattern_tail", 1'b0);
    for (int i = 0; i < 5; i++) got[4-i] = out_q[DEPTH-1+i];
    chk("pattern_seq", (got === pat), 1'b1);

    // 5: random streaming
    for (int i = 0; i < 64; i++) tick("stream", logic'($urandom_range(0, 1)));

    // 6: an unknown value travels through unchanged
    out_q.delete();
    tick("x_in", 1'bx);
    x_sampled = hist[hist.size()-1];
    for (int i = 0; i < 3; i++) tick("x_follow", logic'($urandom_range(0, 1)));
    chk("x_out", out_q[DEPTH-1], x_sampled);

    // 6b: clear mid-stream with ones in flight
    tick("inflight", 1'b1);
    tick("inflight", 1'b1);
    tick("inflight", 1'b1);
    async_clear("midstream_clear");
    tick("clear_hold", 1'b1);
    tick("clear_hold", 1'b1);
    release_clear();
    out_q.delete();
    for (int i = 0; i < 6; i++) tick("no_stale", 1'b0);
    ones = 0;
    foreach (out_q[i]) if (out_q[i] !== RST_V) ones++;
    chk("no_stale_bits", (ones == 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
